mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the EX stage of the MIPS datapath.
- Owns the architectural HI/LO registers.
- Hi/Lo outputs feed the EX result-select mux that chooses among ALU result, HI and LO for MFHI/MFLO.
- Busy drives the hazard unit, which stalls any MFHI/MFLO/MULT/DIV issued while an operation is in flight.

---
 rtl/mult_div_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative multiply/divide unit for the EX stage. It owns the
//                architectural HI/LO registers. MULT/MULTU use radix-2
//                shift-add on operand magnitudes. DIV/DIVU use restoring
//                shift-subtract. A final FIX cycle applies the result signs.
//                MTHI/MTLO write HI/LO directly from A while idle.
//  Ports       : Clk        - rising-edge clock
//                Reset      - synchronous active-high reset
//                Start      - request, accepted only while Busy=0
//                Op[2:0]    - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                             100 MTHI, 101 MTLO, 11x ignored
//                A, B       - rs / rt operands
//                Hi, Lo     - architectural HI / LO registers
//                Busy       - operation in flight (CALC or FIX)
//                Done       - one-cycle completion pulse
//                DivByZero  - one-cycle pulse, with Done, for a divide by 0
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Shared working register:
  //   multiply : {partial product high, multiplier bits still to be consumed}
  //   divide   : {partial remainder, dividend bits / quotient bits}
  logic [2*DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0]   r_opnd;     // multiplicand or divisor magnitude
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_is_div;
  logic                    r_neg_q;    // negate product / quotient
  logic                    r_neg_r;    // negate remainder (dividend sign)

  // ---------------------------------------------------------------- decode
  logic w_op_mul;
  logic w_op_div;
  logic w_op_mthi;
  logic w_op_mtlo;
  logic w_signed;
  logic w_b_zero;
  logic w_accept;
  logic w_launch;
  logic w_dbz;

  assign w_op_mul  = (Op[2:1] == 2'b00);
  assign w_op_div  = (Op[2:1] == 2'b01);
  assign w_op_mthi = (Op == 3'b100);
  assign w_op_mtlo = (Op == 3'b101);
  assign w_signed  = ~Op[0];
  assign w_b_zero  = (B == '0);
  assign w_accept  = Start && (r_state == S_IDLE);
  assign w_launch  = w_accept && (w_op_mul || (w_op_div && !w_b_zero));
  assign w_dbz     = w_accept && w_op_div && w_b_zero;

  // Operand magnitudes; unsigned ops use the raw bits. The most negative
  // value maps onto itself, which is the correct unsigned magnitude.
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_a_mag;
  logic [DATA_WIDTH-1:0] w_b_mag;

  assign w_a_neg = w_signed && A[DATA_WIDTH-1];
  assign w_b_neg = w_signed && B[DATA_WIDTH-1];
  assign w_a_mag = w_a_neg ? (-A) : A;
  assign w_b_mag = w_b_neg ? (-B) : B;

  // ------------------------------------------------------ iteration steps
  // Multiply: add the multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  logic [DATA_WIDTH:0]     w_mul_sum;
  logic [2*DATA_WIDTH-1:0] w_mul_step;

  assign w_mul_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opnd} : {(DATA_WIDTH+1){1'b0}});
  assign w_mul_step = {w_mul_sum, r_acc[DATA_WIDTH-1:1]};

  // Divide: shift the next dividend bit into the remainder and subtract the
  // divisor if it fits. The remainder stays below the divisor, so the
  // shifted value needs one extra bit for the comparison only.
  logic [DATA_WIDTH:0]     w_div_shift;
  logic                    w_div_fits;
  logic [DATA_WIDTH-1:0]   w_div_diff;
  logic [2*DATA_WIDTH-1:0] w_div_step;

  assign w_div_shift = {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]};
  assign w_div_fits  = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[DATA_WIDTH-1:0] - r_opnd;
  assign w_div_step  = w_div_fits
                     ? {w_div_diff, r_acc[DATA_WIDTH-2:0], 1'b1}
                     : {w_div_shift[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b0};

  // ---------------------------------------------------------- sign fix-up
  logic [2*DATA_WIDTH-1:0] w_prod_fix;
  logic [DATA_WIDTH-1:0]   w_quo_fix;
  logic [DATA_WIDTH-1:0]   w_rem_fix;

  assign w_prod_fix = r_neg_q ? (-r_acc) : r_acc;
  assign w_quo_fix  = r_neg_q ? (-r_acc[DATA_WIDTH-1:0]) : r_acc[DATA_WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? (-r_acc[2*DATA_WIDTH-1:DATA_WIDTH])
                              : r_acc[2*DATA_WIDTH-1:DATA_WIDTH];

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == C_LAST_ITER) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign Busy = (r_state != S_IDLE);

  // ------------------------------------------------------------- datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Hi        <= '0;
      Lo        <= '0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_op_mthi) Hi <= A;
          if (w_accept && w_op_mtlo) Lo <= A;
          if (w_dbz) begin
            Done      <= 1'b1;
            DivByZero <= 1'b1;
          end
          if (w_launch) begin
            r_cnt    <= '0;
            r_is_div <= w_op_div;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_acc    <= {{DATA_WIDTH{1'b0}}, (w_op_div ? w_a_mag : w_b_mag)};
            r_opnd   <= w_op_div ? w_b_mag : w_a_mag;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (r_is_div) begin
            Hi <= w_rem_fix;
            Lo <= w_quo_fix;
          end else begin
            Hi <= w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            Lo <= w_prod_fix[DATA_WIDTH-1:0];
          end
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Self-checking bench for mult_div_unit. Directed cases from
//                the test plan plus randomized operations compared against
//                a plain-arithmetic HI/LO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  localparam int W = 32;
  localparam int C_BUSY_CYCLES = W + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         dbz;

  int n_checks = 0;
  int n_fails  = 0;

  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  mult_div_unit #(.DATA_WIDTH(W)) u_dut (
    .Clk       (clk),
    .Reset     (rst),
    .Start     (start),
    .Op        (op),
    .A         (a),
    .B         (b),
    .Hi        (hi),
    .Lo        (lo),
    .Busy      (busy),
    .Done      (done),
    .DivByZero (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic void model_op(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint      sx;
    longint      sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = m_hi;
    rl = m_lo;
    case (o)
      3'b000: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      3'b001: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
      3'b010: begin rl = 32'(sx / sy); rh = 32'(sx % sy); end
      3'b011: begin rl = x / y; rh = x % y; end
      default: ;
    endcase
  endfunction

  // Called at a negedge: present a request for one edge, then scramble A/B.
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Called at the negedge after start_op. Returns at the negedge where Done
  // is seen. Optionally presents an MTLO request while the unit is busy.
  task automatic wait_done(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input bit inject);
    int   busy_cnt;
    bit   seen;
    bit   held;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    busy_cnt = 0; seen = 0; held = 1;
    model_op(o, x, y, eh, el);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (done) begin seen = 1; break; end
      if (busy) busy_cnt++;
      if (hi !== m_hi || lo !== m_lo) held = 0;
      start = inject && (cyc == 9);
      op = 3'b101; a = $urandom; b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(C_BUSY_CYCLES));
    check_eq({tag, "_hilo_held"}, 64'(held), 64'd1);
    check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check_eq({tag, "_dbz"}, 64'(dbz), 64'd0);
    check_eq({tag, "_hi"}, 64'(hi), 64'(eh));
    check_eq({tag, "_lo"}, 64'(lo), 64'(el));
    m_hi = eh; m_lo = el;
  endtask

  task automatic run_arith(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y);
    start_op(o, x, y);
    wait_done(tag, o, x, y, 1'b0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic run_move(input string tag, input logic [2:0] o, input logic [W-1:0] x);
    start_op(o, x, '0);
    if (o == 3'b100) m_hi = x;
    if (o == 3'b101) m_lo = x;
    check_eq({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(m_lo));
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic run_dbz(input string tag, input logic [2:0] o, input logic [W-1:0] x);
    start_op(o, x, '0);
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    check_eq({tag, "_dbz"}, 64'(dbz), 64'd1);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check_eq({tag, "_lo"}, 64'(lo), 64'(m_lo));
    @(negedge clk);
    check_eq({tag, "_pulse_end"}, 64'({done, dbz}), 64'd0);
  endtask

  initial begin
    int done_cnt;
    logic [2:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset_hi", 64'(hi), 64'd0);
    check_eq("reset_lo", 64'(lo), 64'd0);
    check_eq("reset_ctl", 64'({busy, done, dbz}), 64'd0);

    // Moves
    run_move("mthi", 3'b100, 32'h12345678);
    run_move("mtlo", 3'b101, 32'hCAFEF00D);

    // Reserved opcodes change nothing
    run_move("rsv6", 3'b110, 32'hDEADBEEF);
    run_move("rsv7", 3'b111, 32'hDEADBEEF);

    // Directed arithmetic
    run_arith("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7);
    check_eq("mult_neg_val", 64'({hi, lo}), 64'hFFFFFFFF_FFFFFFEB);
    run_arith("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_eq("multu_max_val", 64'({hi, lo}), 64'hFFFFFFFE_00000001);
    run_arith("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2);
    check_eq("div_neg_val", 64'({hi, lo}), 64'hFFFFFFFF_FFFFFFFD);
    run_arith("divu", 3'b011, 32'd100, 32'd7);
    check_eq("divu_val", 64'({hi, lo}), 64'h00000002_0000000E);
    run_arith("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF);
    check_eq("div_ovf_val", 64'({hi, lo}), 64'h00000000_80000000);

    // Divide by zero with preloaded HI/LO
    run_move("pre_hi", 3'b100, 32'h11);
    run_move("pre_lo", 3'b101, 32'h22);
    run_dbz("divu_zero", 3'b011, 32'd5);
    run_dbz("div_zero", 3'b010, 32'hFFFFFFF0);

    // In-flight MTLO ignored, then back-to-back MULT on the Done cycle
    start_op(3'b000, 32'd6, 32'd7);
    wait_done("mult_inj", 3'b000, 32'd6, 32'd7, 1'b1);
    check_eq("mult_inj_val", 64'({hi, lo}), 64'd42);
    start_op(3'b000, 32'hFFFFFF00, 32'h00012345);
    wait_done("b2b", 3'b000, 32'hFFFFFF00, 32'h00012345, 1'b0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(1, 15));
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      if (ro[1] && rb == '0) rb = 32'd3;
      run_arith("rand", ro, ra, rb);
    end

    // Reset in the middle of an operation
    start_op(3'b000, 32'd1234, 32'd5678);
    repeat (14) @(negedge clk);
    check_eq("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_hilo", 64'({hi, lo}), 64'd0);
    check_eq("abort_done", 64'({done, dbz}), 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check_eq("abort_idle_quiet", 64'(done_cnt), 64'd0);
    check_eq("abort_idle_hilo", 64'({hi, lo}), 64'd0);

    // Unit usable after the abort
    run_arith("post_abort", 3'b010, 32'hFFFFFF9C, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
